note_result_stabilizer: RTL

- Sits downstream of the note recogniser and upstream of the SVGA note display.
- Consumes the raw per-frame result d2_recognize_result, qualified by the one-cycle strobe d2_recognize_result_step.
- Declares a note only after STABLE_CNT consecutive identical results. Drops the note on silence or on timeout.
- Decodes the stable note into octave/semitone and keeps a circular history of accepted notes for on-screen readout.

---
 rtl/note_result_stabilizer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/note_result_stabilizer.sv
`default_nettype none
// ============================================================================
// Module   : note_result_stabilizer
// Purpose  : Debounces the per-frame note recogniser result. A note is
//            declared only after STABLE_CNT consecutive identical strobed
//            results, and is dropped on sustained silence or when the strobe
//            stops for TIMEOUT_CYC clocks. The stable note is decoded into
//            octave/semitone, and every accepted non-silent note is pushed
//            into a circular history for on-screen readout.
// Ports    : clk                       system clock
//            reset_p                   asynchronous active-high reset
//            d2_recognize_result       raw note index (0 = none)
//            d2_recognize_result_step  one-cycle strobe qualifying the result
//            hist_clr                  synchronous clear of history ptr/count
//            note / note_vld           stable note and its nonzero flag
//            note_chg                  one-cycle pulse on every note change
//            note_oct / note_semi      (note-1)/12 and (note-1)%12, 0 if none
//            rd_addr / rd_data         history read (0 = newest), 1 clk latency
//            hist_cnt                  valid history entries, saturating
// Revision : 1.0 - initial release
// ============================================================================
module note_result_stabilizer #(
  parameter int NOTE_W      = 6,
  parameter int N_NOTES     = 36,
  parameter int STABLE_CNT  = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int HIST_DEPTH  = 16,
  localparam int OCT_W      = $clog2(N_NOTES / 12 + 1),
  localparam int HA_W       = $clog2(HIST_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic [NOTE_W-1:0] d2_recognize_result,
  input  logic              d2_recognize_result_step,
  input  logic              hist_clr,
  output logic [NOTE_W-1:0] note,
  output logic              note_vld,
  output logic              note_chg,
  output logic [OCT_W-1:0]  note_oct,
  output logic [3:0]        note_semi,
  input  logic [HA_W-1:0]   rd_addr,
  output logic [NOTE_W-1:0] rd_data,
  output logic [HA_W:0]     hist_cnt
);

  localparam int HC_W   = HA_W + 1;
  localparam int IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [NOTE_W-1:0] C_MAX_NOTE  = NOTE_W'(N_NOTES);
  localparam logic [7:0]        C_STABLE    = 8'(STABLE_CNT);
  localparam logic [HC_W-1:0]   C_DEPTH     = HC_W'(HIST_DEPTH);
  localparam logic [IDLE_W-1:0] C_IDLE_TERM = IDLE_W'(TIMEOUT_CYC);
  localparam logic [IDLE_W-1:0] C_IDLE_LAST =
      IDLE_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NOTE_W-1:0]   cand_q, cand_d;
  logic [7:0]          run_q, run_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [OCT_W-1:0]    oct_q, oct_d;
  logic [3:0]          semi_q, semi_d;
  logic                chg_q, chg_d;
  logic [HA_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [HC_W-1:0]     cnt_q, cnt_d;
  logic [NOTE_W-1:0]   rd_data_q, rd_data_d;
  logic [NOTE_W-1:0]   mem_q [HIST_DEPTH];

  logic [NOTE_W-1:0]   r_san;
  logic                accept;
  logic                tmo_fire;
  logic                wr_en;
  logic [HA_W-1:0]     wr_idx;
  logic [HA_W-1:0]     rd_idx;

  function automatic logic [OCT_W-1:0] f_oct(input logic [NOTE_W-1:0] n);
    logic [NOTE_W-1:0] idx;
    idx = n - NOTE_W'(1);
    return OCT_W'(idx / NOTE_W'(12));
  endfunction

  function automatic logic [3:0] f_semi(input logic [NOTE_W-1:0] n);
    logic [NOTE_W-1:0] idx;
    idx = n - NOTE_W'(1);
    return 4'(idx % NOTE_W'(12));
  endfunction

  // Out-of-range indices are treated as silence so they can still drop a note.
  assign r_san = (d2_recognize_result == '0 || d2_recognize_result > C_MAX_NOTE)
                 ? '0 : d2_recognize_result;

  // Candidate tracking, acceptance and timeout.
  always_comb begin
    cand_d   = cand_q;
    run_d    = run_q;
    idle_d   = idle_q;
    note_d   = note_q;
    oct_d    = oct_q;
    semi_d   = semi_q;
    chg_d    = 1'b0;
    accept   = 1'b0;
    tmo_fire = 1'b0;
    if (d2_recognize_result_step) begin
      // A step always wins over a timeout landing in the same cycle.
      idle_d = '0;
      if (r_san == cand_q) begin
        run_d = (run_q >= C_STABLE) ? C_STABLE : run_q + 8'd1;
      end else begin
        cand_d = r_san;
        run_d  = 8'd1;
      end
      if (run_d == C_STABLE && cand_d != note_q) begin
        accept = 1'b1;
        note_d = cand_d;
        chg_d  = 1'b1;
        oct_d  = (cand_d == '0) ? '0 : f_oct(cand_d);
        semi_d = (cand_d == '0) ? '0 : f_semi(cand_d);
      end
    end else if (TIMEOUT_CYC > 0) begin
      // Counter parks at the terminal value so the drop fires only once.
      if (idle_q != C_IDLE_TERM) begin
        idle_d = idle_q + IDLE_W'(1);
      end
      if (idle_q == C_IDLE_LAST) begin
        tmo_fire = 1'b1;
        note_d   = '0;
        oct_d    = '0;
        semi_d   = '0;
        cand_d   = '0;
        run_d    = 8'd0;
        chg_d    = (note_q != '0);
      end
    end
  end

  // Mode tracking: IDLE (no note), TRACK (note held, new candidate), LOCKED.
  always_comb begin
    state_d = state_q;
    if (tmo_fire || (accept && cand_d == '0)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) state_d = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (d2_recognize_result_step && r_san != note_q) state_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (accept || (d2_recognize_result_step && cand_d == note_q))
            state_d = ST_LOCKED;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // History pointer/count. A clear in the same cycle as a write makes the
  // write land at entry 0.
  assign wr_en  = accept && (cand_d != '0);
  assign wr_idx = hist_clr ? '0 : wr_ptr_q;

  always_comb begin
    wr_ptr_d = hist_clr ? '0 : wr_ptr_q;
    cnt_d    = hist_clr ? '0 : cnt_q;
    if (wr_en) begin
      wr_ptr_d = wr_idx + HA_W'(1);
      if (cnt_d != C_DEPTH) cnt_d = cnt_d + HC_W'(1);
    end
  end

  // Newest entry sits just below wr_ptr; the index wraps naturally.
  assign rd_idx    = wr_ptr_q - HA_W'(1) - rd_addr;
  assign rd_data_d = ({1'b0, rd_addr} < cnt_q) ? mem_q[rd_idx] : '0;

  // History storage is never reset; hist_cnt masks stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= cand_d;
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q   <= ST_IDLE;
      cand_q    <= '0;
      run_q     <= 8'd0;
      idle_q    <= '0;
      note_q    <= '0;
      oct_q     <= '0;
      semi_q    <= '0;
      chg_q     <= 1'b0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      run_q     <= run_d;
      idle_q    <= idle_d;
      note_q    <= note_d;
      oct_q     <= oct_d;
      semi_q    <= semi_d;
      chg_q     <= chg_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign note      = note_q;
  assign note_vld  = (note_q != '0);
  assign note_chg  = chg_q;
  assign note_oct  = oct_q;
  assign note_semi = semi_q;
  assign rd_data   = rd_data_q;
  assign hist_cnt  = cnt_q;

endmodule
`default_nettype wire
